grf_writeback: RTL and testbench

- Writeback-stage consumer of the W-stage control decode, fused with the general register file (GRF).
- Takes the W-stage write-enable, data-select and register-select codes plus the W-stage datapath values. Resolves the final write address and data, and commits the write to a 32x32 register file at the clock edge.
- Serves two combinational read ports to the D stage.
- This block is the reader/consumer end of the W-stage writeback control interface.

---
 rtl/grf_writeback.sv | 117 +++++++++++
 tb/tb_grf_writeback.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_writeback.sv
// -----------------------------------------------------------------------------
// grf_writeback
//
// Writeback stage fused with the 32 x DATA_W general register file.
//
// The block decodes the W-stage write-enable and the two select codes into a
// final write address and write data. It commits at most one write per rising
// clk edge. Two combinational read ports serve the D stage. Register 0 always
// reads as zero and is never written.
//
// Configuration macro:
//   GRF_BYPASS_EN  When defined, a read port whose address matches a pending
//                  write returns the write data in the same cycle
//                  (write-through). When undefined, the port returns the
//                  stored value until the edge.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous reset, active low
//   W_GRF_WE   in   1       W-stage register write enable
//   s_W_Wdata  in   2       write-data select: 00/11 ALU, 01 DM, 10 PC+link offset
//   s_W_Wreg   in   2       write-address select: 00 rd, 01 rt, 10 RA_REG, 11 none
//   W_rt       in   5       instruction rt field
//   W_rd       in   5       instruction rd field
//   W_ALU_out  in   DATA_W  ALU result
//   W_DM_out   in   DATA_W  data-memory load result
//   W_PC       in   32      PC of the W-stage instruction
//   D_A1/D_A2  in   5       read addresses
//   D_RD1/D_RD2 out DATA_W  read data
//   W_Waddr    out  5       resolved write address (0 = no commit)
//   W_Wdata    out  DATA_W  resolved write data (for forwarding)
//   wb_cnt     out  32      count of committed writes to non-zero registers
// -----------------------------------------------------------------------------
module grf_writeback #(
    parameter int DATA_W      = 32,
    parameter int RA_REG      = 31,
    parameter int PC_LINK_OFF = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_GRF_WE,
    input  logic [1:0]        s_W_Wdata,
    input  logic [1:0]        s_W_Wreg,
    input  logic [4:0]        W_rt,
    input  logic [4:0]        W_rd,
    input  logic [DATA_W-1:0] W_ALU_out,
    input  logic [DATA_W-1:0] W_DM_out,
    input  logic [31:0]       W_PC,
    input  logic [4:0]        D_A1,
    input  logic [4:0]        D_A2,
    output logic [DATA_W-1:0] D_RD1,
    output logic [DATA_W-1:0] D_RD2,
    output logic [4:0]        W_Waddr,
    output logic [DATA_W-1:0] W_Wdata,
    output logic [31:0]       wb_cnt
);

    // Entry 0 is held at zero by reset and never written, so it is a constant.
    logic [DATA_W-1:0] rf_q [32];
    logic [31:0]       wb_cnt_q, wb_cnt_d;
    logic [4:0]        cand_addr;
    logic [31:0]       link_data;
    logic              commit;

    assign link_data = W_PC + 32'(PC_LINK_OFF);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        cand_addr = '0;
        W_Wdata   = W_ALU_out;
        case (s_W_Wreg)
            2'b00:   cand_addr = W_rd;
            2'b01:   cand_addr = W_rt;
            2'b10:   cand_addr = 5'(RA_REG);
            default: cand_addr = '0;
        endcase
        case (s_W_Wdata)
            2'b01:   W_Wdata = W_DM_out;
            2'b10:   W_Wdata = DATA_W'(link_data);
            default: W_Wdata = W_ALU_out;
        endcase
    end

    assign W_Waddr  = W_GRF_WE ? cand_addr : 5'd0;
    // A zero address covers both "write disabled" and "write to r0": both are dropped.
    assign commit   = (W_Waddr != 5'd0);
    assign wb_cnt_d = commit ? wb_cnt_q + 32'd1 : wb_cnt_q;
    assign wb_cnt   = wb_cnt_q;

    // NOTE: the register file must clear asynchronously, so it is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
            wb_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (commit) begin
                rf_q[W_Waddr] <= W_Wdata;
            end
            wb_cnt_q <= wb_cnt_d;
        end
    end

    always_comb begin
        D_RD1 = (D_A1 == 5'd0) ? '0 : rf_q[D_A1];
        D_RD2 = (D_A2 == 5'd0) ? '0 : rf_q[D_A2];
`ifdef GRF_BYPASS_EN
        // Write-through. Gated by reset so the ports read zero while reset is asserted.
        // commit already excludes address 0.
        if (reset && commit && (D_A1 == W_Waddr)) D_RD1 = W_Wdata;
        if (reset && commit && (D_A2 == W_Waddr)) D_RD2 = W_Wdata;
`endif
    end

endmodule

// File: tb/tb_grf_writeback.sv
`timescale 1ns/1ps
module tb_grf_writeback;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset;
    logic        W_GRF_WE;
    logic [1:0]  s_W_Wdata, s_W_Wreg;
    logic [4:0]  W_rt, W_rd, D_A1, D_A2;
    logic [31:0] W_ALU_out, W_DM_out, W_PC;
    logic [31:0] D_RD1, D_RD2, W_Wdata, wb_cnt;
    logic [4:0]  W_Waddr;

    grf_writeback dut (
        .clk(clk), .reset(reset), .W_GRF_WE(W_GRF_WE),
        .s_W_Wdata(s_W_Wdata), .s_W_Wreg(s_W_Wreg),
        .W_rt(W_rt), .W_rd(W_rd), .W_ALU_out(W_ALU_out), .W_DM_out(W_DM_out),
        .W_PC(W_PC), .D_A1(D_A1), .D_A2(D_A2), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .W_Waddr(W_Waddr), .W_Wdata(W_Wdata), .wb_cnt(wb_cnt)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents and the commit counter.
    logic [31:0] m_rf [32];
    logic [31:0] m_cnt;

    function automatic logic [4:0] exp_waddr();
        if (!W_GRF_WE) return 5'd0;
        case (s_W_Wreg)
            2'b00:   return W_rd;
            2'b01:   return W_rt;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata();
        case (s_W_Wdata)
            2'b01:   return W_DM_out;
            2'b10:   return W_PC + 32'd8;
            default: return W_ALU_out;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && reset && exp_waddr() != 5'd0 && a == exp_waddr()) return exp_wdata();
        return m_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_cnt = 32'd0;
    endtask

    // The model commits on the edge only if reset is high and the target is non-zero.
    always @(posedge clk) begin
        if (reset === 1'b1 && exp_waddr() != 5'd0) begin
            m_rf[exp_waddr()] = exp_wdata();
            m_cnt = m_cnt + 32'd1;
        end
    end

    // Compare process: checks all outputs at mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_waddr", {27'd0, W_Waddr}, {27'd0, exp_waddr()});
            check("cmp_wdata", W_Wdata, exp_wdata());
            check("cmp_wbcnt", wb_cnt, m_cnt);
            check("cmp_rd1", D_RD1, exp_read(D_A1));
            check("cmp_rd2", D_RD2, exp_read(D_A2));
        end
    end

    task automatic drive(input logic we, input logic [1:0] sd, input logic [1:0] sr,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] pc);
        W_GRF_WE = we; s_W_Wdata = sd; s_W_Wreg = sr; W_rt = rt; W_rd = rd;
        W_ALU_out = alu; W_DM_out = dm; W_PC = pc;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'b11, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset is held low from time zero with the clock stopped.
        reset = 1'b0;
        idle();
        model_clear();
        D_A1 = 5'd0; D_A2 = 5'd0;
        #1;
        for (int i = 0; i < 32; i++) begin
            D_A1 = 5'(i); D_A2 = 5'(31 - i);
            #1;
            check("rst_rd1", D_RD1, 32'd0);
            check("rst_rd2", D_RD2, 32'd0);
        end
        check("rst_wbcnt", wb_cnt, 32'd0);

        clk_run = 1'b1;
        tick();
        reset = 1'b1;
        chk_en = 1'b1;

        // R-type write to r8.
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd8, 32'h1234_5678, 32'd0, 32'd0);
        tick();
        idle(); D_A1 = 5'd8;
        #1;
        check("rtype_r8", D_RD1, 32'h1234_5678);
        check("rtype_cnt", wb_cnt, 32'd1);

        // Load to r9, then link to r31.
        drive(1'b1, 2'b01, 2'b01, 5'd9, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'd0);
        tick();
        drive(1'b1, 2'b10, 2'b10, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0000_3000);
        tick();
        idle(); D_A1 = 5'd9; D_A2 = 5'd31;
        #1;
        check("load_r9", D_RD1, 32'hDEAD_BEEF);
        check("link_r31", D_RD2, 32'h0000_3008);
        check("ld_link_cnt", wb_cnt, 32'd3);  // two commits on top of the earlier one

        // A write aimed at r0 is dropped.
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        D_A1 = 5'd0;
        #1;
        check("zero_waddr", {27'd0, W_Waddr}, 32'd0);
        check("zero_rd_pre", D_RD1, 32'd0);
        tick();
        check("zero_rd_post", D_RD1, 32'd0);
        check("zero_cnt", wb_cnt, 32'd3);

        // Same-cycle read of a register being written.
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd5, 32'h1, 32'd0, 32'd0);
        tick();
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd5, 32'h2, 32'd0, 32'd0);
        D_A2 = 5'd5;
        #1;
        check("hazard_pre", D_RD2, BYP ? 32'h2 : 32'h1);
        tick();
        idle();
        #1;
        check("hazard_post", D_RD2, 32'h2);

        // Asynchronous reset between edges after writing r3.
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd3, 32'h55, 32'd0, 32'd0);
        tick();
        idle(); D_A1 = 5'd3;
        #1;
        check("r3_written", D_RD1, 32'h55);
        reset = 1'b0;
        model_clear();
        #1;
        check("arst_rd1", D_RD1, 32'd0);
        check("arst_cnt", wb_cnt, 32'd0);
        tick();
        reset = 1'b1;

        // Link address wraps past 2^32.
        drive(1'b1, 2'b10, 2'b10, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        #1;
        check("wrap_wdata", W_Wdata, 32'h0000_0004);
        check("wrap_waddr", {27'd0, W_Waddr}, 32'd31);
        tick();
        idle(); D_A1 = 5'd31;
        #1;
        check("wrap_r31", D_RD1, 32'h0000_0004);

        // Randomized traffic. Reads are biased toward the write target, with occasional mid-cycle resets.
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
                  5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            D_A1 = $urandom_range(0, 1) ? W_rd : 5'($urandom);
            D_A2 = $urandom_range(0, 1) ? W_rt : 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b0;
                model_clear();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
